// File: rtl/riscv_mc_controller_v2.sv
// Multicycle Moore control unit for the 16-bit RISC-V core: memory handshake with
// watchdog, sticky HALT/TRAP terminal states and cycle / retired-instruction counters.
module riscv_mc_controller_v2 #(
  parameter int OP_W     = 3,
  parameter int CNT_W    = 16,
  parameter int MAX_WAIT = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [OP_W-1:0]  op,
  input  logic [2:0]       func3,
  input  logic [1:0]       Branch_funct,
  input  logic             zero,
  input  logic             less_greater,
  input  logic             mem_ready,
  output logic             PCWrite,
  output logic             adrSrc,
  output logic             memWrite,
  output logic             IRWrite,
  output logic             regWrite,
  output logic             mem_req,
  output logic [1:0]       resultSrc,
  output logic [1:0]       ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [2:0]       ALUControl,
  output logic [2:0]       immSrc,
  output logic             halted,
  output logic             trap,
  output logic [1:0]       trap_cause,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instr_cnt
);

  localparam int WAIT_W = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT + 1);

  typedef enum logic [3:0] {
    RST_IDLE, FETCH, DECODE, EXEC_R, EXEC_I, ALU_WB, MEM_ADDR, MEM_READ,
    MEM_WB, MEM_WRITE, BRANCH, JAL, LUI, HALT, TRAP
  } state_e;

  state_e             state_q, state_d;
  logic [1:0]         cause_q, cause_d;
  logic [WAIT_W-1:0]  wait_q, wait_d;
  logic [CNT_W-1:0]   cycle_q, instr_q;

  logic [2:0] op_lo;
  logic       op_illegal;
  logic       mem_phase;
  logic       timeout;
  logic       taken;
  logic       active;
  logic       retire;

  assign op_lo      = op[2:0];
  assign op_illegal = (op >> 3) != '0;
  assign mem_phase  = (state_q == FETCH) || (state_q == MEM_READ) || (state_q == MEM_WRITE);
  // Fires on the MAX_WAIT-th consecutive unanswered request cycle; mem_ready overrides it.
  assign timeout    = (MAX_WAIT != 0) && mem_phase && !mem_ready &&
                      (int'(wait_q) == MAX_WAIT - 1);
  assign active     = !((state_q == RST_IDLE) || (state_q == HALT) || (state_q == TRAP));
  assign retire     = (state_d == FETCH) &&
                      ((state_q == ALU_WB) || (state_q == MEM_WB) ||
                       (state_q == MEM_WRITE) || (state_q == BRANCH));

  always_comb begin
    case (Branch_funct)
      2'b00:   taken = zero;
      2'b01:   taken = !zero;
      2'b10:   taken = less_greater;
      default: taken = !less_greater;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    cause_d    = cause_q;
    PCWrite    = 1'b0;
    adrSrc     = 1'b0;
    memWrite   = 1'b0;
    IRWrite    = 1'b0;
    regWrite   = 1'b0;
    mem_req    = 1'b0;
    resultSrc  = 2'b00;
    ALUSrcA    = 2'b00;
    ALUSrcB    = 2'b00;
    ALUControl = 3'b000;
    immSrc     = 3'b000;
    halted     = 1'b0;
    trap       = 1'b0;
    case (state_q)
      RST_IDLE: state_d = FETCH;
      FETCH: begin
        mem_req   = 1'b1;
        ALUSrcB   = 2'b10;
        resultSrc = 2'b10;
        IRWrite   = mem_ready;
        PCWrite   = mem_ready;
        if (mem_ready) begin
          state_d = DECODE;
        end else if (timeout) begin
          state_d = TRAP;
          cause_d = 2'b10;
        end
      end
      DECODE: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
        immSrc  = (op == OP_W'(5)) ? 3'b011 : 3'b010;
        if (op_illegal) begin
          state_d = TRAP;
          cause_d = 2'b01;
        end else begin
          case (op_lo)
            3'b000:  state_d = EXEC_R;
            3'b001:  state_d = EXEC_I;
            3'b010,
            3'b011:  state_d = MEM_ADDR;
            3'b100:  state_d = BRANCH;
            3'b101:  state_d = JAL;
            3'b110:  state_d = LUI;
            default: begin
              if (func3 == 3'b000) begin
                state_d = HALT;
              end else begin
                state_d = TRAP;
                cause_d = 2'b11;
              end
            end
          endcase
        end
      end
      EXEC_R: begin
        ALUSrcA    = 2'b10;
        ALUControl = func3;
        state_d    = ALU_WB;
      end
      EXEC_I: begin
        ALUSrcA    = 2'b10;
        ALUSrcB    = 2'b01;
        ALUControl = func3;
        state_d    = ALU_WB;
      end
      ALU_WB: begin
        regWrite = 1'b1;
        state_d  = FETCH;
      end
      MEM_ADDR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        immSrc  = (op_lo == 3'b011) ? 3'b001 : 3'b000;
        state_d = (op_lo == 3'b011) ? MEM_WRITE : MEM_READ;
      end
      MEM_READ: begin
        mem_req = 1'b1;
        adrSrc  = 1'b1;
        if (mem_ready) begin
          state_d = MEM_WB;
        end else if (timeout) begin
          state_d = TRAP;
          cause_d = 2'b10;
        end
      end
      MEM_WB: begin
        resultSrc = 2'b01;
        regWrite  = 1'b1;
        state_d   = FETCH;
      end
      MEM_WRITE: begin
        mem_req  = 1'b1;
        adrSrc   = 1'b1;
        memWrite = !timeout;
        if (mem_ready) begin
          state_d = FETCH;
        end else if (timeout) begin
          state_d = TRAP;
          cause_d = 2'b10;
        end
      end
      BRANCH: begin
        ALUSrcA    = 2'b10;
        ALUControl = 3'b001;
        PCWrite    = taken;
        state_d    = FETCH;
      end
      JAL: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b10;
        PCWrite = 1'b1;
        state_d = ALU_WB;
      end
      LUI: begin
        ALUSrcA = 2'b11;
        ALUSrcB = 2'b01;
        immSrc  = 3'b100;
        state_d = ALU_WB;
      end
      HALT:    halted = 1'b1;
      TRAP:    trap   = 1'b1;
      default: state_d = RST_IDLE;
    endcase
  end

  always_comb begin
    wait_d = wait_q;
    if ((state_d != state_q) || mem_ready) begin
      wait_d = '0;
    end else if (mem_phase) begin
      wait_d = wait_q + WAIT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= RST_IDLE;
      cause_q <= '0;
      wait_q  <= '0;
      cycle_q <= '0;
      instr_q <= '0;
    end else begin
      state_q <= state_d;
      cause_q <= cause_d;
      wait_q  <= wait_d;
      if (active) cycle_q <= cycle_q + CNT_W'(1);
      if (retire) instr_q <= instr_q + CNT_W'(1);
    end
  end

  assign trap_cause = cause_q;
  assign cycle_cnt  = cycle_q;
  assign instr_cnt  = instr_q;

endmodule

// File: tb/tb_riscv_mc_controller_v2.sv
// Randomised bench for riscv_mc_controller_v2: an instruction-level step model predicts
// every output each cycle, and directed sequences pin the model with literal values.
module tb_riscv_mc_controller_v2;
  localparam int OP_W     = 4;
  localparam int CNT_W    = 4;
  localparam int MAX_WAIT = 4;
  localparam int CMOD     = 1 << CNT_W;

  // bit positions inside the packed control word
  localparam int B_PCW = 19, B_ADR = 18, B_MW = 17, B_IRW = 16, B_RW = 15, B_MRQ = 14;
  localparam int B_HLT = 1, B_TRP = 0;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [OP_W-1:0] op = '0;
  logic [2:0] func3 = '0;
  logic [1:0] Branch_funct = '0;
  logic zero = 1'b0, less_greater = 1'b0, mem_ready = 1'b0;
  logic PCWrite, adrSrc, memWrite, IRWrite, regWrite, mem_req, halted, trap;
  logic [1:0] resultSrc, ALUSrcA, ALUSrcB, trap_cause;
  logic [2:0] ALUControl, immSrc;
  logic [CNT_W-1:0] cycle_cnt, instr_cnt;

  always #5 clk = ~clk;

  riscv_mc_controller_v2 #(.OP_W(OP_W), .CNT_W(CNT_W), .MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .rst(rst), .op(op), .func3(func3), .Branch_funct(Branch_funct),
    .zero(zero), .less_greater(less_greater), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .adrSrc(adrSrc), .memWrite(memWrite), .IRWrite(IRWrite),
    .regWrite(regWrite), .mem_req(mem_req), .resultSrc(resultSrc), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ALUControl(ALUControl), .immSrc(immSrc), .halted(halted),
    .trap(trap), .trap_cause(trap_cause), .cycle_cnt(cycle_cnt), .instr_cnt(instr_cnt)
  );

  logic [19:0] dut_ctrl;
  assign dut_ctrl = {PCWrite, adrSrc, memWrite, IRWrite, regWrite, mem_req, resultSrc,
                     ALUSrcA, ALUSrcB, ALUControl, immSrc, halted, trap};

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
  endtask

  // Model: the step the controller is in, the steps left for this instruction,
  // cycles spent waiting in the current memory step, and architectural counters.
  string m_cur = "IDLE";
  string m_rest[$];
  int    m_waited = 0;
  int    m_cause = 0;
  int    m_cycles = 0;
  int    m_instrs = 0;

  logic [19:0] exp_ctrl;
  logic [7:0]  exp_cnt;
  logic [1:0]  exp_cause;
  logic [19:0] snap;
  bit          check_en = 1'b0;

  function automatic bit is_mem_step();
    return (m_cur == "F") || (m_cur == "MR") || (m_cur == "MW");
  endfunction

  function automatic bit watchdog_fires();
    return is_mem_step() && !mem_ready && (MAX_WAIT != 0) && (m_waited == MAX_WAIT - 1);
  endfunction

  function automatic logic [19:0] model_ctrl();
    logic pcw, adr, mw, irw, rw, mrq, hl, tr, br_cond;
    logic [1:0] rs, sa, sb;
    logic [2:0] alc, imm;
    {pcw, adr, mw, irw, rw, mrq, hl, tr} = '0;
    rs = 2'b00; sa = 2'b00; sb = 2'b00; alc = 3'b000; imm = 3'b000;
    br_cond = (Branch_funct[1] ? less_greater : zero) ^ Branch_funct[0];
    if (m_cur == "F") begin
      mrq = 1; sb = 2'b10; rs = 2'b10; irw = mem_ready; pcw = mem_ready;
    end else if (m_cur == "D") begin
      sa = 2'b01; sb = 2'b01; imm = (op == OP_W'(5)) ? 3'b011 : 3'b010;
    end else if (m_cur == "XR") begin
      sa = 2'b10; alc = func3;
    end else if (m_cur == "XI") begin
      sa = 2'b10; sb = 2'b01; alc = func3;
    end else if (m_cur == "WB") begin
      rw = 1;
    end else if (m_cur == "MA") begin
      sa = 2'b10; sb = 2'b01; imm = (op == OP_W'(3)) ? 3'b001 : 3'b000;
    end else if (m_cur == "MR") begin
      mrq = 1; adr = 1;
    end else if (m_cur == "MWB") begin
      rs = 2'b01; rw = 1;
    end else if (m_cur == "MW") begin
      mrq = 1; adr = 1; mw = !watchdog_fires();
    end else if (m_cur == "BR") begin
      sa = 2'b10; alc = 3'b001; pcw = br_cond;
    end else if (m_cur == "J") begin
      sa = 2'b01; sb = 2'b10; pcw = 1;
    end else if (m_cur == "L") begin
      sa = 2'b11; sb = 2'b01; imm = 3'b100;
    end else if (m_cur == "HALT") begin
      hl = 1;
    end else if (m_cur == "TRAP") begin
      tr = 1;
    end
    return {pcw, adr, mw, irw, rw, mrq, rs, sa, sb, alc, imm, hl, tr};
  endfunction

  task automatic model_edge();
    if (!rst) begin
      m_cur = "IDLE"; m_rest.delete(); m_waited = 0; m_cause = 0; m_cycles = 0; m_instrs = 0;
      return;
    end
    if (m_cur == "IDLE") begin m_cur = "F"; m_waited = 0; return; end
    if (m_cur == "HALT" || m_cur == "TRAP") return;
    m_cycles = (m_cycles + 1) % CMOD;
    if (is_mem_step() && !mem_ready) begin
      if (watchdog_fires()) begin m_cur = "TRAP"; m_cause = 2; end
      else m_waited++;
      return;
    end
    m_waited = 0;
    if (m_cur == "F") begin
      m_cur = "D";
    end else if (m_cur == "D") begin
      if (op > 7) begin m_cur = "TRAP"; m_cause = 1; end
      else case (int'(op))
        0: begin m_cur = "XR"; m_rest.push_back("WB"); end
        1: begin m_cur = "XI"; m_rest.push_back("WB"); end
        2: begin m_cur = "MA"; m_rest.push_back("MR"); m_rest.push_back("MWB"); end
        3: begin m_cur = "MA"; m_rest.push_back("MW"); end
        4: m_cur = "BR";
        5: begin m_cur = "J"; m_rest.push_back("WB"); end
        6: begin m_cur = "L"; m_rest.push_back("WB"); end
        default: begin
          if (func3 == 3'b000) m_cur = "HALT";
          else begin m_cur = "TRAP"; m_cause = 3; end
        end
      endcase
    end else if (m_rest.size() > 0) begin
      m_cur = m_rest.pop_front();
    end else begin
      // every instruction that completes without trapping retires on its return to fetch
      m_instrs = (m_instrs + 1) % CMOD;
      m_cur = "F";
    end
  endtask

  task automatic cyc(input logic r, input logic rdy);
    rst = r;
    mem_ready = rdy;
    exp_ctrl  = model_ctrl();
    exp_cnt   = {4'(m_cycles), 4'(m_instrs)};
    exp_cause = 2'(m_cause);
    @(negedge clk);
    snap = dut_ctrl;
    @(posedge clk);
    model_edge();
    #1;
  endtask

  always @(negedge clk) begin
    if (check_en) begin
      chk("ctrl", 32'(dut_ctrl), 32'(exp_ctrl));
      chk("counters", 32'({cycle_cnt, instr_cnt}), 32'(exp_cnt));
      chk("trap_cause", 32'(trap_cause), 32'(exp_cause));
    end
  end

  task automatic run_instr(input int n_steps);
    for (int k = 0; k < n_steps; k++) cyc(1'b1, 1'b1);
  endtask

  task automatic pick_instr();
    int sel;
    sel = $urandom_range(0, 99);
    func3 = 3'($urandom_range(0, 7));
    if (sel < 88) op = OP_W'($urandom_range(0, 6));
    else if (sel < 94) begin
      op = OP_W'(7);
      if ($urandom_range(0, 1) == 0) func3 = 3'b000;
    end else op = OP_W'(8 + $urandom_range(0, 7));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int cnt;
    logic irw_seen;
    logic r;
    rst = 1'b0;
    mem_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    model_edge();
    check_en = 1'b1;

    // reset state
    cyc(1'b0, 1'b1);
    chk("reset_ctrl", 32'(snap), 32'd0);
    chk("reset_cycle", 32'(cycle_cnt), 32'd0);

    // R add, single-cycle memory
    op = 4'd0; func3 = 3'd0;
    cyc(1'b1, 1'b1);
    run_instr(3);
    cyc(1'b1, 1'b1);
    chk("r_regwrite", 32'(snap[B_RW]), 32'd1);
    chk("r_instr_cnt", 32'(instr_cnt), 32'd1);
    chk("r_cycle_cnt", 32'(cycle_cnt), 32'd4);

    // LOAD with three wait states
    op = 4'd2;
    run_instr(3);
    cnt = 0;
    for (int k = 0; k < 4; k++) begin
      cyc(1'b1, k == 3);
      if (snap[B_MRQ] && snap[B_ADR]) cnt++;
    end
    chk("load_wait_cycles", 32'(cnt), 32'd4);
    cyc(1'b1, 1'b1);
    chk("load_wb_regwrite", 32'(snap[B_RW]), 32'd1);
    chk("load_no_trap", 32'(snap[B_TRP]), 32'd0);

    // branches
    op = 4'd4; Branch_funct = 2'b11; less_greater = 1'b1;
    run_instr(3);
    chk("bge_lt_not_taken", 32'(snap[B_PCW]), 32'd0);
    less_greater = 1'b0;
    run_instr(3);
    chk("bge_ge_taken", 32'(snap[B_PCW]), 32'd1);
    Branch_funct = 2'b00; zero = 1'b1;
    run_instr(3);
    chk("beq_taken", 32'(snap[B_PCW]), 32'd1);

    // fetch timeout
    cyc(1'b0, 1'b0);
    cyc(1'b1, 1'b0);
    op = 4'd0;
    irw_seen = 1'b0;
    for (int k = 0; k < MAX_WAIT; k++) begin
      cyc(1'b1, 1'b0);
      irw_seen |= snap[B_IRW];
    end
    chk("timeout_no_irwrite", 32'(irw_seen), 32'd0);
    cyc(1'b1, 1'b0);
    chk("timeout_trap", 32'(snap[B_TRP]), 32'd1);
    chk("timeout_cause", 32'(trap_cause), 32'd2);

    // ready on the limit cycle wins
    cyc(1'b0, 1'b1);
    cyc(1'b1, 1'b0);
    for (int k = 0; k < MAX_WAIT; k++) cyc(1'b1, k == MAX_WAIT - 1);
    cyc(1'b1, 1'b1);
    chk("limit_ready_decode_srcA", 32'(snap[11:10]), 32'd1);
    chk("limit_ready_no_trap", 32'(snap[B_TRP]), 32'd0);
    cyc(1'b1, 1'b1);

    // HALT freezes cycle counter
    cyc(1'b0, 1'b1);
    cyc(1'b1, 1'b1);
    op = 4'd7; func3 = 3'd0;
    run_instr(5);
    chk("halt_flag", 32'(snap[B_HLT]), 32'd1);
    chk("halt_cycle_frozen", 32'(cycle_cnt), 32'd2);

    // bad SYSTEM func3, then one-edge reset
    cyc(1'b0, 1'b1);
    cyc(1'b1, 1'b1);
    func3 = 3'd2;
    run_instr(3);
    chk("sys_trap", 32'(snap[B_TRP]), 32'd1);
    chk("sys_cause", 32'(trap_cause), 32'd3);
    cyc(1'b0, 1'b1);
    cyc(1'b1, 1'b0);
    chk("post_reset_idle", 32'(snap), 32'd0);
    chk("post_reset_cause", 32'(trap_cause), 32'd0);
    cyc(1'b1, 1'b0);
    chk("post_reset_fetch", 32'(snap[B_MRQ]), 32'd1);

    // illegal upper opcode bits
    cyc(1'b0, 1'b1);
    cyc(1'b1, 1'b1);
    op = 4'b1001;
    run_instr(3);
    chk("illegal_cause", 32'(trap_cause), 32'd1);

    // counter wrap with 16 R instructions
    cyc(1'b0, 1'b1);
    cyc(1'b1, 1'b1);
    op = 4'd0;
    for (int k = 0; k < 15; k++) run_instr(4);
    chk("instr_cnt_15", 32'(instr_cnt), 32'd15);
    chk("cycle_cnt_60", 32'(cycle_cnt), 32'd12);
    run_instr(4);
    chk("instr_cnt_wrap", 32'(instr_cnt), 32'd0);
    chk("cycle_cnt_wrap", 32'(cycle_cnt), 32'd0);

    // randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      r = 1'b1;
      if (m_cur == "HALT" || m_cur == "TRAP") r = ($urandom_range(0, 3) != 0);
      else if ($urandom_range(0, 199) == 0) r = 1'b0;
      if (m_cur == "F" && m_waited == 0) pick_instr();
      zero = 1'($urandom_range(0, 1));
      less_greater = 1'($urandom_range(0, 1));
      Branch_funct = 2'($urandom_range(0, 3));
      cyc(r, $urandom_range(0, 9) < 6);
    end

    check_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/riscv_mc_controller_v2.md
Name: riscv_mc_controller_v2

Overview:
Parametrised next-generation multicycle control unit for the 16-bit RISC-V core. It is an explicit Moore FSM that drives datapath mux selects and enables. Beyond the previous controller it adds:
- a memory ready/request handshake with wait states and a watchdog timeout;
- HALT and TRAP terminal states with a cause code;
- cycle and retired-instruction counters.
It sits between the instruction register / ALU flags and the datapath.

Parameters:
OP_W, 3, opcode width; bits above [2:0] must be zero or the opcode is illegal
CNT_W, 16, width of cycle_cnt and instr_cnt
MAX_WAIT, 15, max cycles mem_req may stay high without mem_ready before timeout trap; 0 disables timeout

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous active-low reset; state and counters reset on a clk edge with rst=0
op  in  OP_W  opcode: 000 R, 001 I-ALU, 010 LOAD, 011 STORE, 100 BRANCH, 101 JAL, 110 LUI, 111 SYSTEM
func3  in  3  ALU function / SYSTEM sub-op
Branch_funct  in  2  00 beq, 01 bne, 10 blt, 11 bge
zero  in  1  ALU zero flag
less_greater  in  1  ALU signed-less flag
mem_ready  in  1  memory completes the current request this cycle
PCWrite, adrSrc, memWrite, IRWrite, regWrite, mem_req  out  1 each  datapath enables/selects
resultSrc  out  2  00 ALUOut, 01 read data, 10 ALU result
ALUSrcA  out  2  00 PC, 01 oldPC, 10 rs1, 11 zero
ALUSrcB  out  2  00 rs2, 01 imm, 10 constant 2
ALUControl  out  3  000 add, 001 sub; other codes are func3 passed through
immSrc  out  3  000 I, 001 S, 010 B, 011 J, 100 U
halted, trap  out  1 each  sticky status
trap_cause  out  2  00 none, 01 illegal op, 10 mem timeout, 11 bad SYSTEM func3
cycle_cnt, instr_cnt  out  CNT_W each  performance counters

Behaviour:
- Outputs are combinational decodes of the state register, plus mem_ready/flag qualification where noted. Any output not listed for a state is 0.
- rst=0 at a clk edge:
  - state <= RST_IDLE;
  - counters, trap_cause and the wait counter <= 0.
  - Reset mid-operation (including mid-handshake) aborts immediately.
  - In RST_IDLE all outputs are 0.
- RST_IDLE -> FETCH, unconditionally, once rst=1.
- FETCH:
  - mem_req=1, adrSrc=0, ALUSrcA=00, ALUSrcB=10, add, resultSrc=10.
  - IRWrite=PCWrite=mem_ready.
  - Holds while mem_ready=0; goes to DECODE when mem_ready=1.
- DECODE:
  - ALUSrcA=01, ALUSrcB=01, add; immSrc=011 if op=JAL, else 010.
  - Next state by op: R -> EXEC_R; I -> EXEC_I; LOAD/STORE -> MEM_ADDR; BRANCH -> BRANCH; JAL -> JAL; LUI -> LUI.
  - SYSTEM with func3=000 -> HALT; SYSTEM with other func3 -> TRAP, cause 11.
  - Nonzero op[OP_W-1:3] -> TRAP, cause 01.
- EXEC_R: ALUSrcA=10, ALUSrcB=00, ALUControl=func3 -> ALU_WB.
- EXEC_I: ALUSrcA=10, ALUSrcB=01, immSrc=000, ALUControl=func3 -> ALU_WB.
- ALU_WB: resultSrc=00, regWrite=1 -> FETCH.
- MEM_ADDR: ALUSrcA=10, ALUSrcB=01, add; immSrc=000 for LOAD, 001 for STORE -> MEM_READ or MEM_WRITE.
- MEM_READ: mem_req=1, adrSrc=1; hold until mem_ready -> MEM_WB.
- MEM_WB: resultSrc=01, regWrite=1 -> FETCH.
- MEM_WRITE: mem_req=1, adrSrc=1, memWrite=1; all held until mem_ready -> FETCH.
- BRANCH:
  - ALUSrcA=10, ALUSrcB=00, sub, resultSrc=00 (target from DECODE).
  - PCWrite=taken, where taken = zero / !zero / less_greater / !less_greater for Branch_funct 00/01/10/11.
  - -> FETCH.
- JAL: ALUSrcA=01, ALUSrcB=10, add, resultSrc=00, PCWrite=1 -> ALU_WB (writes PC+2 to rd).
- LUI: ALUSrcA=11, ALUSrcB=01, immSrc=100, add -> ALU_WB.
- HALT: halted=1; stays until reset.
- TRAP: trap=1, trap_cause held; stays until reset. No PCWrite, regWrite or memWrite in either terminal state.
- Watchdog:
  - The wait counter increments each cycle mem_req=1 and mem_ready=0, and clears on mem_ready or on a state change.
  - If MAX_WAIT!=0 and the counter reaches MAX_WAIT with mem_ready still 0, next state is TRAP with cause 10. memWrite/IRWrite are never asserted in that cycle.
  - mem_ready in the same cycle the limit is reached wins: normal transition, no trap.
- cycle_cnt: +1 every cycle the state is not RST_IDLE, HALT or TRAP.
- instr_cnt: +1 on each transition into FETCH from ALU_WB, MEM_WB, MEM_WRITE or BRANCH.
- Both counters wrap modulo 2^CNT_W.

Test Plan:
- R add with mem_ready tied 1: FETCH, DECODE, EXEC_R, ALU_WB -> regWrite=1 in cycle 4; instr_cnt=1, cycle_cnt=4.
- LOAD with mem_ready low for 3 cycles in MEM_READ -> adrSrc=1 and mem_req=1 held for 4 cycles, then MEM_WB regWrite=1; no trap.
- BRANCH bge with less_greater=1 -> PCWrite=0; repeat with less_greater=0 -> PCWrite=1 in the BRANCH cycle; beq with zero=1 -> PCWrite=1.
- MAX_WAIT=4, mem_ready held 0 in FETCH -> TRAP, trap_cause=10, IRWrite never 1; a second run with mem_ready=1 on the limit cycle -> DECODE.
- op=111, func3=000 -> halted=1, cycle_cnt frozen; func3=010 -> trap_cause=11; rst=0 for one edge -> all outputs 0, then FETCH.
- CNT_W=4, 16 single-cycle-memory R instructions -> instr_cnt wraps to 0.
